// File: rtl/rob_alloc.sv
// rob_alloc: in-order ROB slot allocator on the issue side of the reorder buffer.
// Hands out one slot index per cycle from a wrapping tail pointer. The head
// pointer advances on retire pulses from the ROB head. Occupancy is tracked in a
// separate counter, because head == tail holds both when the buffer is empty
// and when it is full.
// Optional build macro: ROB_ALLOC_CHECK_EN enables a sticky protocol error flag.
// The flag catches a retire while empty, and allocReq held against a full buffer
// for more than 255 consecutive cycles. Without the macro, error is tied to 0.
//
// Handshake: the issue stage holds allocReq high until allocGnt is 1. In that
// same cycle it tags the instruction with allocIdx. The grant is combinational
// from registered state and never depends on a same-cycle retire.
module rob_alloc #(
  parameter int ROB_SLOTS       = 16,
  parameter int ROB_IDX_BITS    = 4,
  parameter int ALMOST_FULL_THR = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    allocReq,
  output logic                    allocGnt,
  output logic [ROB_IDX_BITS-1:0] allocIdx,
  input  logic                    retire,
  output logic [ROB_IDX_BITS-1:0] headIdx,
  output logic [ROB_IDX_BITS:0]   count,
  output logic                    empty,
  output logic                    full,
  output logic                    almostFull,
  output logic                    error
);

  localparam logic [ROB_IDX_BITS-1:0] LAST_IDX = ROB_IDX_BITS'(ROB_SLOTS - 1);
  localparam logic [ROB_IDX_BITS:0]   SLOTS_C  = (ROB_IDX_BITS+1)'(ROB_SLOTS);
  localparam logic [ROB_IDX_BITS:0]   THR_C    = (ROB_IDX_BITS+1)'(ALMOST_FULL_THR);

  logic [ROB_IDX_BITS-1:0] r_tail;
  logic [ROB_IDX_BITS-1:0] r_head;
  logic [ROB_IDX_BITS:0]   r_count;

  logic                    w_empty;
  logic                    w_full;
  logic                    w_alloc;
  logic                    w_ret;
  logic [ROB_IDX_BITS:0]   w_free;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == SLOTS_C);
  assign w_free  = SLOTS_C - r_count;

  // A flush or reset cycle swallows both request and retire.
  assign w_alloc = allocReq && !w_full && !rst && !clear;
  assign w_ret   = retire && !w_empty && !rst && !clear;

  assign allocGnt   = w_alloc;
  assign allocIdx   = r_tail;
  assign headIdx    = r_head;
  assign count      = r_count;
  assign empty      = w_empty;
  assign full       = w_full;
  assign almostFull = (w_free <= THR_C);

  // Pointer and occupancy update; explicit wrap compare so any slot count works.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_tail  <= '0;
      r_head  <= '0;
      r_count <= '0;
    end else begin
      if (w_alloc) r_tail <= (r_tail == LAST_IDX) ? '0 : r_tail + 1'b1;
      if (w_ret)   r_head <= (r_head == LAST_IDX) ? '0 : r_head + 1'b1;
      if (w_alloc && !w_ret)      r_count <= r_count + 1'b1;
      else if (!w_alloc && w_ret) r_count <= r_count - 1'b1;
    end
  end

`ifdef ROB_ALLOC_CHECK_EN
  logic [7:0] r_stall;
  logic       r_error;
  logic       w_stalled;

  assign w_stalled = allocReq && w_full && !clear;
  assign error     = r_error;

  // Sticky error: retire with nothing allocated, or a stall of more than 255 cycles.
  // Only rst clears it; a pipeline flush leaves it set.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall <= '0;
      r_error <= 1'b0;
    end else begin
      if (w_stalled) begin
        if (r_stall != 8'hFF) r_stall <= r_stall + 1'b1;
        else                  r_error <= 1'b1;
      end else begin
        r_stall <= '0;
      end
      if (retire && w_empty && !clear) r_error <= 1'b1;
    end
  end
`else
  assign error = 1'b0;
`endif

endmodule

// File: tb/tb_rob_alloc.sv
// Bench for rob_alloc: 16-slot instance with a reference model and a grant-index
// scoreboard, plus a 12-slot instance exercised with directed steps.
module tb_rob_alloc;

  localparam int N = 16;

`ifdef ROB_ALLOC_CHECK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       clear, allocReq, retire;
  logic       allocGnt, empty, full, almostFull, error;
  logic [3:0] allocIdx, headIdx;
  logic [4:0] count;

  logic       s_clear, s_req, s_ret;
  logic       t_gnt, t_empty, t_full, t_af, t_err;
  logic [3:0] t_idx, t_head;
  logic [4:0] t_count;

  int n_checks = 0;
  int n_err    = 0;

  logic [3:0] exp_q[$];

  // Reference model state for the 16-slot instance.
  int m_tail = 0;
  int m_head = 0;
  int m_count = 0;

  always #5 clk = ~clk;

  rob_alloc #(.ROB_SLOTS(16), .ROB_IDX_BITS(4), .ALMOST_FULL_THR(2)) u_dut (
    .clk(clk), .rst(rst), .clear(clear), .allocReq(allocReq), .allocGnt(allocGnt),
    .allocIdx(allocIdx), .retire(retire), .headIdx(headIdx), .count(count),
    .empty(empty), .full(full), .almostFull(almostFull), .error(error)
  );

  rob_alloc #(.ROB_SLOTS(12), .ROB_IDX_BITS(4), .ALMOST_FULL_THR(2)) u_dut12 (
    .clk(clk), .rst(rst), .clear(s_clear), .allocReq(s_req), .allocGnt(t_gnt),
    .allocIdx(t_idx), .retire(s_ret), .headIdx(t_head), .count(t_count),
    .empty(t_empty), .full(t_full), .almostFull(t_af), .error(t_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One cycle on the 16-slot instance: drive inputs, check outputs, update model.
  task automatic step(input logic a, input logic r, input logic c);
    logic exp_gnt;
    logic ret_ok;
    allocReq = a;
    retire   = r;
    clear    = c;
    #3;
    exp_gnt = a && (m_count != N) && !c && !rst;
    ret_ok  = r && (m_count != 0) && !c && !rst;
    chk("gnt",        32'(allocGnt),   32'(exp_gnt));
    chk("count",      32'(count),      32'(m_count));
    chk("head",       32'(headIdx),    32'(m_head));
    chk("alloc_idx",  32'(allocIdx),   32'(m_tail));
    chk("empty",      32'(empty),      32'(m_count == 0));
    chk("full",       32'(full),       32'(m_count == N));
    chk("almostFull", 32'(almostFull), 32'((N - m_count) <= 2));
    if (exp_gnt) exp_q.push_back(4'(m_tail));
    if (allocGnt === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_err++;
        $error("FAIL sb_unexpected_grant observed=%0d expected=none", allocIdx);
      end else begin
        chk("sb_idx", 32'(allocIdx), 32'(exp_q.pop_front()));
      end
    end
    if (rst || c) begin
      m_tail = 0; m_head = 0; m_count = 0;
    end else begin
      if (exp_gnt) m_tail = (m_tail == N - 1) ? 0 : m_tail + 1;
      if (ret_ok)  m_head = (m_head == N - 1) ? 0 : m_head + 1;
      m_count = m_count + int'(exp_gnt) - int'(ret_ok);
    end
    tick();
  endtask

  // Drive the 12-slot instance and let the combinational outputs settle.
  task automatic drive12(input logic a, input logic r, input logic c);
    s_req   = a;
    s_ret   = r;
    s_clear = c;
    #3;
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; allocReq = 1'b1; retire = 1'b0;
    s_clear = 1'b0; s_req = 1'b0; s_ret = 1'b0;
    tick();

    // T1: reset held with a pending request.
    step(1, 0, 0);
    step(1, 0, 0);
    rst = 1'b0;

    // T2: fill, 17 requests, the last one refused.
    for (int i = 0; i < 17; i++) begin
      if (i == 14) chk("t2_af_at_14", 32'(almostFull), 32'(1));
      if (i == 13) chk("t2_af_at_13", 32'(almostFull), 32'(0));
      step(1, 0, 0);
    end
    chk("t2_count16", 32'(count), 32'(16));
    chk("t2_full",    32'(full),  32'(1));

    // T3: full with retire in the same cycle does not grant.
    allocReq = 1'b1; retire = 1'b1; #3;
    chk("t3_no_bypass", 32'(allocGnt), 32'(0));
    step(1, 1, 0);
    chk("t3_head1",   32'(headIdx), 32'(1));
    chk("t3_count15", 32'(count),   32'(15));
    allocReq = 1'b1; retire = 1'b0; #3;
    chk("t3_regrant", 32'(allocGnt), 32'(1));
    chk("t3_idx0",    32'(allocIdx), 32'(0));
    step(1, 0, 0);

    // T4: drain to 3, then steady alloc+retire across the wrap.
    for (int i = 0; i < 13; i++) step(0, 1, 0);
    chk("t4_start3", 32'(count), 32'(3));
    for (int i = 0; i < 40; i++) begin
      step(1, 1, 0);
      chk("t4_trail", 32'((allocIdx - headIdx) & 4'hF), 32'(3));
    end
    chk("t4_count3", 32'(count), 32'(3));

    // T5: clear at count 9 with request and retire both high.
    for (int i = 0; i < 6; i++) step(1, 0, 0);
    chk("t5_count9", 32'(count), 32'(9));
    step(1, 1, 1);
    chk("t5_cnt0",  32'(count),    32'(0));
    chk("t5_head0", 32'(headIdx),  32'(0));
    chk("t5_idx0",  32'(allocIdx), 32'(0));
    step(1, 0, 0);
    step(0, 1, 0);
    step(0, 1, 0);  // retire while empty: no change
    chk("t5_no_underflow", 32'(count), 32'(0));
    chk("t5_err16", 32'(error), 32'(CHK));
    chk("t5_sb_drained", 32'(exp_q.size()), 32'(0));

    // T6: 12-slot instance, grants 0..11 in order.
    rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      drive12(1, 0, 0);
      chk("t6_gnt", 32'(t_gnt), 32'(1));
      chk("t6_idx", 32'(t_idx), 32'(i));
      tick();
    end
    chk("t6_full", 32'(t_full), 32'(1));
    chk("t6_count12", 32'(t_count), 32'(12));
    // Stall against full: 255 stalled cycles are tolerated, the 256th flags.
    for (int i = 0; i < 255; i++) begin
      drive12(1, 0, 0);
      if (i == 0) chk("t6_gnt_full", 32'(t_gnt), 32'(0));
      tick();
    end
    chk("t6_stall255", 32'(t_err), 32'(0));
    drive12(1, 0, 0); tick();
    chk("t6_stall256", 32'(t_err), 32'(CHK));
    // Retire one, then the next grant wraps to index 0.
    drive12(0, 1, 0); tick();
    chk("t6_head1", 32'(t_head), 32'(1));
    drive12(1, 0, 0);
    chk("t6_wrap_gnt", 32'(t_gnt), 32'(1));
    chk("t6_wrap_idx", 32'(t_idx), 32'(0));
    tick();
    chk("t6_tail_eq_head", 32'(t_idx), 32'(t_head));

    // Retire while empty after a fresh reset.
    drive12(0, 0, 0);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("t6_err_rst", 32'(t_err), 32'(0));
    drive12(0, 1, 0); tick();
    chk("t6_empty_cnt", 32'(t_count), 32'(0));
    chk("t6_err_set", 32'(t_err), 32'(CHK));
    drive12(0, 0, 1); tick();
    chk("t6_err_sticky", 32'(t_err), 32'(CHK));
    drive12(0, 0, 0);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("t6_err_clr", 32'(t_err), 32'(0));
    chk("t6_empty", 32'(t_empty), 32'(1));
    chk("t6_af0", 32'(t_af), 32'(0));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
